// File: rtl/gpio_in_capture.sv
// GPIO input capture: 2-flop sync + optional per-pin debounce, sticky edge flags, W1C regs, irq.
// Define GPIO_IN_DEBOUNCE_EN to enable the debounce counters; otherwise level tracks the synchronizer.

module gpio_in_pin #(
  parameter int DEBOUNCE_CYCLES = 27000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic upd
);
  logic s1, s2;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
    $error("DEBOUNCE_CYCLES out of range 1..65535");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam logic [15:0] TH = 16'(DEBOUNCE_CYCLES - 1);
  logic [15:0] cnt;

  // upd is the cycle in which level will take s2; the top uses it to set edge flags
  assign upd = (s2 != level) && (cnt == TH);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (upd) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end
`else
  assign upd = (s2 != level);

  always_ff @(posedge clk) begin
    if (rst) level <= 1'b0;
    else     level <= s2;
  end
`endif
endmodule

module gpio_in_capture #(
  parameter int                    ADDR_WIDTH      = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 'h084,
  parameter int                    DEBOUNCE_CYCLES = 27000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            pin_in,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr,
  input  logic                  byt,
  input  logic [15:0]           wr_data,
  output logic [15:0]           rd_data,
  output logic                  hit_d,
  output logic [7:0]            level,
  output logic                  irq
);
  localparam int NUM_PINS = 8;

  if (BASE_ADDR[0] != 1'b0) begin : g_bad_base
    $error("BASE_ADDR must be even");
  end

  logic [NUM_PINS-1:0] upd;
  logic [NUM_PINS-1:0] rise, fall, irq_en;

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_in_pin #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pin (
      .clk   (clk),
      .rst   (rst),
      .pin   (pin_in[i]),
      .level (level[i]),
      .upd   (upd[i])
    );
  end

  // Offset wraps to a large value below BASE, so one compare covers both range ends
  logic [ADDR_WIDTH-1:0] off;
  logic                  hit;
  assign off = addr - BASE_ADDR;
  assign hit = (off[ADDR_WIDTH-1:2] == '0);

  logic                rise_wr, fall_wr, en_wr;
  logic [NUM_PINS-1:0] rise_set, fall_set, rise_clr, fall_clr;

  // Byte lanes: odd offset = high byte (flags), even offset = low byte (level / irq_en)
  assign rise_wr  = wr && hit && !off[1] && (!byt || off[0]);
  assign fall_wr  = wr && hit &&  off[1] && (!byt || off[0]);
  assign en_wr    = wr && hit &&  off[1] && (!byt || !off[0]);
  assign rise_clr = rise_wr ? wr_data[15:8] : '0;
  assign fall_clr = fall_wr ? wr_data[15:8] : '0;
  assign rise_set = upd & ~level;
  assign fall_set = upd &  level;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise    <= '0;
      fall    <= '0;
      irq_en  <= '0;
      irq     <= 1'b0;
      rd_data <= '0;
      hit_d   <= 1'b0;
    end else begin
      rise  <= (rise & ~rise_clr) | rise_set;
      fall  <= (fall & ~fall_clr) | fall_set;
      if (en_wr) irq_en <= wr_data[7:0];
      irq   <= |((rise | fall) & irq_en);
      hit_d <= hit;
      if (!hit)        rd_data <= '0;
      else if (off[1]) rd_data <= {fall, irq_en};
      else             rd_data <= {rise, level};
    end
  end
endmodule

// File: tb/tb_gpio_in_capture.sv
// Directed-vector bench for gpio_in_capture with DEBOUNCE_CYCLES=4 at BASE 12'h084.
module tb_gpio_in_capture;
  localparam logic [11:0] BASE = 12'h084;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int         LAT    = 6;
  localparam logic [7:0] G_RISE = 8'h01;
  localparam logic [7:0] G_FALL = 8'h00;
`else
  localparam int         LAT    = 3;
  localparam logic [7:0] G_RISE = 8'h03;
  localparam logic [7:0] G_FALL = 8'h02;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pin_in;
  logic [11:0] addr;
  logic        wr, byt;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        hit_d;
  logic [7:0]  level;
  logic        irq;

  int nvec = 0;
  int nmis = 0;

  gpio_in_capture #(.ADDR_WIDTH(12), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .addr(addr), .wr(wr), .byt(byt),
    .wr_data(wr_data), .rd_data(rd_data), .hit_d(hit_d), .level(level), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [11:0] a);
    addr = a; wr = 1'b0;
    tick(1);
    addr = 12'h000;
  endtask

  task automatic wrt(input logic [11:0] a, input logic [15:0] d, input logic b);
    addr = a; wr = 1'b1; byt = b; wr_data = d;
    tick(1);
    wr = 1'b0; byt = 1'b0; addr = 12'h000; wr_data = '0;
  endtask

  initial begin
    rst = 1'b1; pin_in = '0; addr = '0; wr = 1'b0; byt = 1'b0; wr_data = '0;
    tick(2);
    chk("rst_level", {8'h0, level}, 16'h0000);
    chk("rst_irq", {15'h0, irq}, 16'h0000);
    chk("rst_hit", {15'h0, hit_d}, 16'h0000);
    chk("rst_rdata", rd_data, 16'h0000);
    rst = 1'b0;

    rd(BASE);       chk("rd0_data", rd_data, 16'h0000); chk("rd0_hit", {15'h0, hit_d}, 16'h0001);
    rd(BASE + 2);   chk("rd2_data", rd_data, 16'h0000); chk("rd2_hit", {15'h0, hit_d}, 16'h0001);
    chk("idle_irq", {15'h0, irq}, 16'h0000);

    // pin 0 rises: level exactly LAT cycles later
    pin_in = 8'h01;
    tick(LAT - 1);  chk("lat_before", {8'h0, level}, 16'h0000);
    tick(1);        chk("lat_at", {8'h0, level}, 16'h0001);
    chk("lat_irq_off", {15'h0, irq}, 16'h0000);
    rd(BASE);       chk("rise_read", rd_data, 16'h0101);

    // 3-cycle pulse on pin 1
    pin_in = 8'h03; tick(3);
    pin_in = 8'h01; tick(LAT + 2);
    chk("glitch_level", {8'h0, level}, 16'h0001);
    rd(BASE);       chk("glitch_rise", rd_data, {G_RISE, 8'h01});
    rd(BASE + 2);   chk("glitch_fall", rd_data, {G_FALL, 8'h00});
    wrt(BASE + 2, 16'hFF00, 1'b0);
    wrt(BASE, 16'hFF00, 1'b0);
    rd(BASE);       chk("clr_rise", rd_data, 16'h0001);
    rd(BASE + 2);   chk("clr_fall", rd_data, 16'h0000);

    // pin 0 falls with irq_en[0]
    wrt(BASE + 2, 16'h0001, 1'b0);
    rd(BASE + 2);   chk("irqen_read", rd_data, 16'h0001);
    pin_in = 8'h00;
    tick(LAT);      chk("fall_level", {8'h0, level}, 16'h0000);
    chk("irq_lag", {15'h0, irq}, 16'h0000);
    tick(1);        chk("irq_set", {15'h0, irq}, 16'h0001);
    rd(BASE + 2);   chk("fall_read", rd_data, 16'h0101);
    wrt(BASE + 2, 16'hFF01, 1'b1);
    rd(BASE + 2);   chk("byte2_keep_fall", rd_data, 16'h0101);
    wrt(BASE + 3, 16'h0100, 1'b1);
    chk("irq_hold", {15'h0, irq}, 16'h0001);
    tick(1);        chk("irq_clr", {15'h0, irq}, 16'h0000);
    rd(BASE + 2);   chk("byte3_clr", rd_data, 16'h0001);

    // rise set and W1C in the same cycle: set wins
    pin_in = 8'h01;
    tick(LAT - 1);
    wrt(BASE, 16'hFF00, 1'b0);
    rd(BASE);       chk("set_wins", rd_data, 16'h0101);
    chk("irq_rise", {15'h0, irq}, 16'h0001);
    wrt(BASE, 16'hFFFF, 1'b1);
    rd(BASE);       chk("byte0_ignored", rd_data, 16'h0101);
    wrt(BASE + 1, 16'h0100, 1'b1);
    rd(BASE);       chk("byte1_clr", rd_data, 16'h0001);
    chk("irq_rise_clr", {15'h0, irq}, 16'h0000);

    // out of range
    rd(BASE + 4);   chk("oor4_data", rd_data, 16'h0000); chk("oor4_hit", {15'h0, hit_d}, 16'h0000);
    rd(12'h080);    chk("oor80_data", rd_data, 16'h0000); chk("oor80_hit", {15'h0, hit_d}, 16'h0000);
    rd(BASE - 1);   chk("oor83_hit", {15'h0, hit_d}, 16'h0000);
    rd(BASE + 3);   chk("in3_data", rd_data, 16'h0001); chk("in3_hit", {15'h0, hit_d}, 16'h0001);
    wrt(BASE + 4, 16'hFFFF, 1'b0);
    rd(BASE);       chk("oorw_reg0", rd_data, 16'h0001);
    rd(BASE + 2);   chk("oorw_reg1", rd_data, 16'h0001);

    // reset mid-debounce, new pin value presented across the reset edge
    pin_in = 8'h00;
    tick(4);
    rst = 1'b1; pin_in = 8'h01;
    tick(1);
    rst = 1'b0;
    chk("mrst_level", {8'h0, level}, 16'h0000);
    chk("mrst_irq", {15'h0, irq}, 16'h0000);
    tick(LAT - 1);  chk("mrst_before", {8'h0, level}, 16'h0000);
    tick(1);        chk("mrst_at", {8'h0, level}, 16'h0001);
    rd(BASE);       chk("mrst_reg0", rd_data, 16'h0101);
    rd(BASE + 2);   chk("mrst_reg1", rd_data, 16'h0000);
    chk("mrst_irq_off", {15'h0, irq}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
